// File: rtl/banked_code_memory.sv
// -----------------------------------------------------------------------------
// banked_code_memory
//
// Word-addressed code/data memory split into NUM_BANKS equal banks of
// BANK_DEPTH words each. Banks with index >= SYS_BANK_FIRST are system banks
// and can only be written by a system-mode requester. After reset the whole
// array is scrubbed to zero, one word per cycle, while oBusy is high; requests
// are ignored until the scrub completes.
//
// Ports
//   iCLK        clock, all state changes on the rising edge
//   iRST        synchronous active-high reset (restarts the scrub)
//   iAddress    64-bit byte address of the request
//   iWriteData  write data, DATA_W bits
//   iMemRead    read request
//   iMemWrite   write request (wins over iMemRead when both are high)
//   iSysMode    requester privilege, 1 = system
//   oMemData    registered read data, held between reads
//   oMemValid   one-cycle pulse, oMemData valid (read latency 1)
//   oBusy       scrub in progress, requests ignored
//   oFault      one-cycle pulse, the request accepted last cycle faulted
//   oFaultCode  last fault: 0 none, 1 misaligned, 2 out-of-range, 3 protection
// -----------------------------------------------------------------------------
module banked_code_memory #(
    parameter int          DATA_W         = 32,
    parameter int          NUM_BANKS      = 2,
    parameter int          BANK_DEPTH     = 1024,
    parameter logic [63:0] BASE_ADDR      = 64'h0,
    parameter int          SYS_BANK_FIRST = 1
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [63:0]       iAddress,
    input  logic [DATA_W-1:0] iWriteData,
    input  logic              iMemRead,
    input  logic              iMemWrite,
    input  logic              iSysMode,
    output logic [DATA_W-1:0] oMemData,
    output logic              oMemValid,
    output logic              oBusy,
    output logic              oFault,
    output logic [1:0]        oFaultCode
);

    // -------------------------------------------------------------------------
    // Geometry
    // -------------------------------------------------------------------------
    localparam int WORD_BYTES  = DATA_W / 8;
    localparam int OFF_BITS    = $clog2(WORD_BYTES);
    localparam int ROW_BITS    = $clog2(BANK_DEPTH);
    localparam int BANK_BITS   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int WORD_BITS   = ROW_BITS + BANK_BITS;
    localparam int TOTAL_WORDS = NUM_BANKS * BANK_DEPTH;

    localparam logic [WORD_BITS-1:0] LAST_WORD      = WORD_BITS'(TOTAL_WORDS - 1);
    localparam logic [63:0]          TOTAL_WORDS_64 = 64'(TOTAL_WORDS);

    typedef enum logic {
        ST_SCRUB,
        ST_READY
    } stateType;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2,
        FAULT_PROT     = 2'd3
    } faultType;

    stateType state;
    stateType nextState;

    logic [WORD_BITS-1:0] scrubCount;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic [63:0]          reqOffset;
    logic [63:0]          reqWord;
    logic [BANK_BITS-1:0] reqBank;
    logic [ROW_BITS-1:0]  reqRow;
    logic                 belowBase;
    logic                 misaligned;
    logic                 outOfRange;
    logic                 sysBank;
    logic                 protViolation;
    faultType             reqFault;
    logic                 reqFaulted;

    // NOTE: every variable written in an always_comb gets a default at the top
    // of the block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        reqFault  = FAULT_NONE;
        reqOffset = iAddress - BASE_ADDR;
        reqWord   = reqOffset >> OFF_BITS;
        reqRow    = reqWord[ROW_BITS-1:0];
        reqBank   = reqWord[WORD_BITS-1:ROW_BITS];

        // The subtract above wraps for addresses below the base; the explicit
        // compare keeps such addresses from aliasing into the valid window.
        belowBase     = iAddress < BASE_ADDR;
        misaligned    = |iAddress[OFF_BITS-1:0];
        outOfRange    = belowBase || (reqWord >= TOTAL_WORDS_64);
        sysBank       = int'(reqBank) >= SYS_BANK_FIRST;
        // Reads from system banks are always allowed; only writes are checked.
        protViolation = iMemWrite && !iSysMode && sysBank;

        if (misaligned) begin
            reqFault = FAULT_MISALIGN;
        end else if (outOfRange) begin
            reqFault = FAULT_RANGE;
        end else if (protViolation) begin
            reqFault = FAULT_PROT;
        end
    end

    assign reqFaulted = (reqFault != FAULT_NONE);

    // -------------------------------------------------------------------------
    // Acceptance: no handshake, any request while READY is taken. A request
    // coincident with reset is dropped so nothing leaks past the restart.
    // -------------------------------------------------------------------------
    logic acceptAny;
    logic acceptWrite;
    logic acceptRead;

    assign acceptAny   = (state == ST_READY) && !iRST && (iMemRead || iMemWrite);
    assign acceptWrite = acceptAny && iMemWrite;
    assign acceptRead  = acceptAny && iMemRead && !iMemWrite;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= ST_SCRUB;
        end else begin
            state <= nextState;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and memory write port selection
    // -------------------------------------------------------------------------
    logic                 memWe;
    logic [BANK_BITS-1:0] memBank;
    logic [ROW_BITS-1:0]  memRow;
    logic [DATA_W-1:0]    memWriteData;

    always_comb begin
        nextState    = state;
        oBusy        = 1'b0;
        memWe        = 1'b0;
        memBank      = scrubCount[WORD_BITS-1:ROW_BITS];
        memRow       = scrubCount[ROW_BITS-1:0];
        memWriteData = '0;

        case (state)
            ST_SCRUB: begin
                oBusy = 1'b1;
                memWe = !iRST;
                if (scrubCount == LAST_WORD) begin
                    nextState = ST_READY;
                end
            end
            ST_READY: begin
                // Faulted writes leave the array untouched.
                if (acceptWrite && !reqFaulted) begin
                    memWe        = 1'b1;
                    memBank      = reqBank;
                    memRow       = reqRow;
                    memWriteData = iWriteData;
                end
            end
            default: begin
                nextState = ST_SCRUB;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Scrub counter: walks the flat word index from bank 0 row 0 upward.
    // -------------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            scrubCount <= '0;
        end else if (state == ST_SCRUB) begin
            if (scrubCount == LAST_WORD) begin
                scrubCount <= '0;
            end else begin
                scrubCount <= scrubCount + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Bank storage
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] bankMem [NUM_BANKS][BANK_DEPTH];

    // NOTE: the array has no reset branch so it maps onto RAM macros; the
    // scrub sequence is what brings it to a known all-zero state.
    always_ff @(posedge iCLK) begin
        if (memWe) begin
            bankMem[memBank][memRow] <= memWriteData;
        end
    end

    // -------------------------------------------------------------------------
    // Response registers. A read the cycle after a write sees the new word
    // because the write has already landed in the array at the earlier edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oMemData   <= '0;
            oMemValid  <= 1'b0;
            oFault     <= 1'b0;
            oFaultCode <= FAULT_NONE;
        end else begin
            oMemValid <= acceptRead;
            oFault    <= acceptAny && reqFaulted;

            if (acceptAny && reqFaulted) begin
                oFaultCode <= reqFault;
            end

            if (acceptRead) begin
                oMemData <= reqFaulted ? '0 : bankMem[reqBank][reqRow];
            end
        end
    end

endmodule

// File: tb/tb_banked_code_memory.sv
// -----------------------------------------------------------------------------
// tb_banked_code_memory
//
// Self-checking bench for banked_code_memory at default parameters
// (32-bit words, 2 banks x 1024, base 0, bank 1 is the system bank).
// A reference word array tracks memory contents; expected read data is queued
// when a read is issued and compared when oMemValid is seen.
// -----------------------------------------------------------------------------
module tb_banked_code_memory;

    localparam int DATA_W      = 32;
    localparam int TOTAL_WORDS = 2048;

    logic              iCLK = 1'b0;
    logic              iRST;
    logic [63:0]       iAddress;
    logic [DATA_W-1:0] iWriteData;
    logic              iMemRead;
    logic              iMemWrite;
    logic              iSysMode;
    logic [DATA_W-1:0] oMemData;
    logic              oMemValid;
    logic              oBusy;
    logic              oFault;
    logic [1:0]        oFaultCode;

    banked_code_memory dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iAddress   (iAddress),
        .iWriteData (iWriteData),
        .iMemRead   (iMemRead),
        .iMemWrite  (iMemWrite),
        .iSysMode   (iSysMode),
        .oMemData   (oMemData),
        .oMemValid  (oMemValid),
        .oBusy      (oBusy),
        .oFault     (oFault),
        .oFaultCode (oFaultCode)
    );

    always #5 iCLK = ~iCLK;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] model [TOTAL_WORDS];
    logic [31:0] expQ [$];
    logic [31:0] lastRead;
    logic [31:0] popped;
    logic [1:0]  modelCode;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < TOTAL_WORDS; i++) model[i] = '0;
        modelCode = 2'd0;
    endtask

    // Read-response monitor: every oMemValid pulse must match a queued read.
    always begin
        @(posedge iCLK);
        #1;
        if (oMemValid === 1'b1) begin
            if (expQ.size() == 0) begin
                check("spurious_valid", 64'd1, 64'd0);
            end else begin
                popped = expQ.pop_front();
                check("read_data", oMemData, popped);
            end
        end
    end

    // One request cycle. 'ready' is the bench's own knowledge of whether the
    // memory has finished scrubbing.
    task automatic issue(input logic rd, input logic wr, input logic [63:0] addr,
                         input logic [31:0] data, input logic sys, input logic ready);
        logic [1:0] code;
        logic       fault;
        logic       isRead;
        iMemRead   = rd;
        iMemWrite  = wr;
        iAddress   = addr;
        iWriteData = data;
        iSysMode   = sys;

        code = 2'd0;
        if (addr[1:0] != 2'b00)                       code = 2'd1;
        else if (addr >= 64'h2000)                    code = 2'd2;
        else if (wr && !sys && addr >= 64'h1000)      code = 2'd3;

        fault  = ready && (rd || wr) && (code != 2'd0);
        isRead = ready && rd && !wr;
        if (ready && wr && code == 2'd0) model[addr[12:2]] = data;
        if (isRead) begin
            lastRead = (code != 2'd0) ? 32'd0 : model[addr[12:2]];
            expQ.push_back(lastRead);
        end
        if (fault) modelCode = code;

        @(posedge iCLK);
        #1;
        iMemRead  = 1'b0;
        iMemWrite = 1'b0;
        check("valid", oMemValid, isRead);
        check("fault", oFault, fault);
        check("fault_code", oFaultCode, modelCode);
    endtask

    // Counts cycles until oBusy falls. Optionally injects a write then a read
    // to an already scrubbed word near the end of the scrub.
    task automatic countBusy(input string tag, input logic inject);
        int  cnt;
        logic done;
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (inject && cnt == 2000) begin
                iMemWrite = 1'b1; iAddress = 64'h10; iWriteData = 32'hBAD0BAD0; iSysMode = 1'b1;
            end else if (inject && cnt == 2001) begin
                iMemWrite = 1'b0; iMemRead = 1'b1; iAddress = 64'h10;
            end else begin
                iMemWrite = 1'b0; iMemRead = 1'b0;
            end
            @(posedge iCLK);
            #1;
            cnt++;
            if (inject && (cnt == 2002 || cnt == 2003)) begin
                check("busy_no_fault", oFault, 1'b0);
                check("busy_no_valid", oMemValid, 1'b0);
            end
            if (oBusy === 1'b0) done = 1'b1;
        end
        iMemWrite = 1'b0;
        iMemRead  = 1'b0;
        check(tag, cnt, 2048);
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_busy"}, oBusy, 1'b1);
        check({tag, "_valid"}, oMemValid, 1'b0);
        check({tag, "_fault"}, oFault, 1'b0);
        check({tag, "_code"}, oFaultCode, 2'd0);
        check({tag, "_data"}, oMemData, 32'd0);
    endtask

    initial begin
        logic [63:0] addr;
        int          r;
        iRST = 1'b0; iAddress = '0; iWriteData = '0;
        iMemRead = 1'b0; iMemWrite = 1'b0; iSysMode = 1'b0;
        lastRead = '0;
        clearModel();

        // Power-up reset and scrub, with requests injected while busy.
        @(posedge iCLK);
        #1;
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        checkResetState("reset");
        countBusy("scrub_cycles", 1'b1);

        // Scrubbed word at the top of bank 0 reads zero.
        issue(1, 0, 64'h0FFC, 32'h0, 0, 1);

        // Write then read back on the next cycle.
        issue(0, 1, 64'h0004, 32'hDEADBEEF, 0, 1);
        issue(1, 0, 64'h0004, 32'h0, 0, 1);

        // Protection on the system bank.
        issue(0, 1, 64'h1000, 32'h1234, 0, 1);
        issue(1, 0, 64'h1000, 32'h0, 0, 1);
        issue(0, 1, 64'h1000, 32'h1234, 1, 1);
        issue(1, 0, 64'h1000, 32'h0, 0, 1);

        // Faulting reads and the last valid word.
        issue(1, 0, 64'h0002, 32'h0, 0, 1);
        issue(1, 0, 64'h2000, 32'h0, 0, 1);
        issue(1, 0, 64'h1FFC, 32'h0, 0, 1);

        // The write issued during the scrub must not have landed.
        issue(1, 0, 64'h0010, 32'h0, 0, 1);

        // Read+write together acts as a write only; read data is held.
        issue(1, 1, 64'h0008, 32'hCAFEF00D, 0, 1);
        check("data_hold", oMemData, lastRead);
        issue(1, 0, 64'h0008, 32'h0, 0, 1);

        // Faulted writes leave memory unchanged.
        issue(0, 1, 64'h0006, 32'h55555555, 1, 1);
        issue(0, 1, 64'h3000, 32'h66666666, 1, 1);
        issue(1, 0, 64'h0004, 32'h0, 0, 1);
        issue(1, 0, 64'h0000, 32'h0, 0, 1);

        // Mixed traffic over both banks.
        for (int i = 0; i < 24; i++) begin
            r    = $urandom_range(0, 5);
            addr = 64'($urandom_range(0, TOTAL_WORDS - 1)) << 2;
            if (r == 5) addr[0] = 1'b1;
            issue((r < 3) || (r == 4), (r >= 3), addr, $urandom, 1'($urandom_range(0, 1)), 1);
        end

        // Reset arriving with a read request: the read is dropped.
        iMemRead = 1'b1; iAddress = 64'h0004; iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0; iMemRead = 1'b0;
        clearModel();
        checkResetState("midop");

        // Reset again part way through the scrub: full restart.
        repeat (500) begin
            @(posedge iCLK);
            #1;
        end
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        countBusy("rescrub_cycles", 1'b0);
        issue(1, 0, 64'h0004, 32'h0, 0, 1);
        issue(1, 0, 64'h1000, 32'h0, 0, 1);

        repeat (3) begin
            @(posedge iCLK);
            #2;
        end
        check("scoreboard_empty", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
